// File: rtl/phase_pkg.sv
// ---------------------------------------------------------------------------
// phase_pkg : shared types and constants for the phase scan sequencer
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package phase_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_GAP  = 2'd3
   } state_e;

   localparam int        PHASE_W_DEF = 16;

   // Galois form of x^8+x^6+x^5+x^4+1, right-shifting
   localparam logic [7:0] LFSR_SEED  = 8'hA5;
   localparam logic [7:0] LFSR_TAPS  = 8'hB8;

endpackage

`default_nettype wire

// File: rtl/lfsr8.sv
// ---------------------------------------------------------------------------
// lfsr8 : 8-bit Galois LFSR phase dither source (built with PHASE_DITHER_EN)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

`ifdef PHASE_DITHER_EN
module lfsr8
   import phase_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [7:0] q
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en) begin
         lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign q = lfsr_q;

endmodule
`endif

`default_nettype wire

// File: rtl/phase_scan_ctrl.sv
// ---------------------------------------------------------------------------
// phase_scan_ctrl : raster scan sequencer emitting per-pixel gradient phase
// Rev 1.0 : initial release; optional dither via `define PHASE_DITHER_EN
// ---------------------------------------------------------------------------
`default_nettype none

module phase_scan_ctrl
   import phase_pkg::*;
#(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int PHASE_W   = PHASE_W_DEF,
   parameter int FRAME_GAP = 4
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [PHASE_W-1:0] h_step,
   input  logic [PHASE_W-1:0] v_step,
   input  logic [PHASE_W-1:0] frame_step,
   output logic [PHASE_W-1:0] phase,
   output logic               px_valid,
   input  logic               px_ready,
   output logic               sof,
   output logic               eol,
   output logic               eof,
   output logic               busy,
   output logic [15:0]        frame_cnt
);

   localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
   localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

   state_e               state_q, state_d;
   logic [XW-1:0]        x_q, x_d;
   logic [YW-1:0]        y_q, y_d;
   logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
   logic [PHASE_W-1:0]   base_q, base_d;
   logic [PHASE_W-1:0]   row_phase_q, row_phase_d;
   logic [PHASE_W-1:0]   pix_phase_q, pix_phase_d;
   logic [PHASE_W-1:0]   h_sh_q, h_sh_d;
   logic [PHASE_W-1:0]   v_sh_q, v_sh_d;
   logic [PHASE_W-1:0]   f_sh_q, f_sh_d;
   logic [15:0]          frame_cnt_q, frame_cnt_d;
   logic                 stop_pend_q, stop_pend_d;

   logic                 run;
   logic                 xfer;
   logic                 last_x;
   logic                 last_y;
   logic                 stop_now;

   assign run      = (state_q == ST_RUN);
   assign xfer     = run && px_ready;
   assign last_x   = (x_q == X_LAST);
   assign last_y   = (y_q == Y_LAST);
   assign stop_now = stop_pend_q | stop;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      gap_cnt_d   = gap_cnt_q;
      base_d      = base_q;
      row_phase_d = row_phase_q;
      pix_phase_d = pix_phase_q;
      h_sh_d      = h_sh_q;
      v_sh_d      = v_sh_q;
      f_sh_d      = f_sh_q;
      frame_cnt_d = frame_cnt_q;
      stop_pend_d = stop_pend_q;

      case (state_q)
         ST_IDLE: begin
            stop_pend_d = 1'b0;
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            h_sh_d      = h_step;
            v_sh_d      = v_step;
            f_sh_d      = frame_step;
            row_phase_d = base_q;
            pix_phase_d = base_q;
            x_d         = '0;
            y_d         = '0;
            stop_pend_d = stop_now;
            state_d     = ST_RUN;
         end
         ST_RUN: begin
            stop_pend_d = stop_now;
            if (xfer) begin
               if (!last_x) begin
                  x_d         = x_q + 1'b1;
                  pix_phase_d = pix_phase_q + h_sh_q;
               end else begin
                  // Next row starts from the updated row accumulator
                  x_d         = '0;
                  y_d         = y_q + 1'b1;
                  row_phase_d = row_phase_q + v_sh_q;
                  pix_phase_d = row_phase_q + v_sh_q;
                  if (last_y) begin
                     y_d         = '0;
                     base_d      = base_q + f_sh_q;
                     frame_cnt_d = frame_cnt_q + 16'd1;
                     if (stop_now) begin
                        stop_pend_d = 1'b0;
                        state_d     = ST_IDLE;
                     end else if (FRAME_GAP > 0) begin
                        gap_cnt_d   = '0;
                        state_d     = ST_GAP;
                     end else begin
                        state_d     = ST_LOAD;
                     end
                  end
               end
            end
         end
         ST_GAP: begin
            stop_pend_d = stop_now;
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = '0;
               if (stop_now) begin
                  stop_pend_d = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  state_d     = ST_LOAD;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         gap_cnt_q   <= '0;
         base_q      <= '0;
         row_phase_q <= '0;
         pix_phase_q <= '0;
         h_sh_q      <= '0;
         v_sh_q      <= '0;
         f_sh_q      <= '0;
         frame_cnt_q <= '0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         gap_cnt_q   <= gap_cnt_d;
         base_q      <= base_d;
         row_phase_q <= row_phase_d;
         pix_phase_q <= pix_phase_d;
         h_sh_q      <= h_sh_d;
         v_sh_q      <= v_sh_d;
         f_sh_q      <= f_sh_d;
         frame_cnt_q <= frame_cnt_d;
         stop_pend_q <= stop_pend_d;
      end
   end

`ifdef PHASE_DITHER_EN
   logic [7:0] lfsr_q;

   lfsr8 u_lfsr8 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (xfer),
      .q     (lfsr_q)
   );

   assign phase = run ? (pix_phase_q + {{(PHASE_W-8){1'b0}}, lfsr_q}) : '0;
`else
   assign phase = run ? pix_phase_q : '0;
`endif

   assign px_valid  = run;
   assign sof       = run && (x_q == '0) && (y_q == '0);
   assign eol       = run && last_x;
   assign eof       = run && last_x && last_y;
   assign busy      = (state_q != ST_IDLE);
   assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phase_scan_ctrl : directed self-checking bench for phase_scan_ctrl
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_phase_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] h_step = '0;
   logic [15:0] v_step = '0;
   logic [15:0] frame_step = '0;
   logic [15:0] phase;
   logic        px_valid;
   logic        px_ready = 1'b1;
   logic        sof, eol, eof, busy;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] got_ph  [32];
   logic        got_sof [32];
   logic        got_eol [32];
   logic        got_eof [32];

   logic [15:0] exp_grad [8] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300,
                                 16'h1000, 16'h1100, 16'h1200, 16'h1300};
   logic [15:0] exp_wrap [4] = '{16'h0000, 16'hC000, 16'h8000, 16'h4000};
   logic [3:0]  bp_pat = 4'b1001;

   phase_scan_ctrl #(
      .H_ACTIVE  (4),
      .V_ACTIVE  (2),
      .PHASE_W   (16),
      .FRAME_GAP (0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .h_step     (h_step),
      .v_step     (v_step),
      .frame_step (frame_step),
      .phase      (phase),
      .px_valid   (px_valid),
      .px_ready   (px_ready),
      .sof        (sof),
      .eol        (eol),
      .eof        (eof),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      px_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Gathers n transfers; bp selects the 1,0,0,1 ready pattern; stop is
   // raised while the stop_at-th pixel (0-based) is being offered.
   task automatic collect(input int n, input bit bp, input int stop_at);
      int          cnt = 0;
      int          cyc = 0;
      bit          stall = 1'b0;
      logic [15:0] h_ph = '0;
      logic [2:0]  h_mk = '0;
      while (cnt < n && cyc < 200) begin
         px_ready = bp ? bp_pat[3 - (cyc % 4)] : 1'b1;
         stop     = (cnt == stop_at);
         #1;
         if (stall) begin
            check_eq("hold_phase", {16'h0, phase}, {16'h0, h_ph});
            check_eq("hold_markers", {29'h0, sof, eol, eof}, {29'h0, h_mk});
         end
         if (px_valid && px_ready) begin
            got_ph[cnt]  = phase;
            got_sof[cnt] = sof;
            got_eol[cnt] = eol;
            got_eof[cnt] = eof;
            cnt++;
         end
         stall = px_valid && !px_ready;
         h_ph  = phase;
         h_mk  = {sof, eol, eof};
         @(negedge clk);
         cyc++;
      end
      stop     = 1'b0;
      px_ready = 1'b1;
      if (cnt < n) check_eq("collect_timeout", cnt, n);
   endtask

   task automatic check_grad_frame(input string tag);
      for (int i = 0; i < 8; i++) begin
         check_eq({tag, "_phase"}, {16'h0, got_ph[i]}, {16'h0, exp_grad[i]});
         check_eq({tag, "_sof"}, {31'h0, got_sof[i]}, {31'h0, i == 0});
         check_eq({tag, "_eol"}, {31'h0, got_eol[i]}, {31'h0, (i == 3) || (i == 7)});
         check_eq({tag, "_eof"}, {31'h0, got_eof[i]}, {31'h0, i == 7});
      end
   endtask

   initial begin
      // Reset state
      do_reset();
      #1;
      check_eq("rst_phase", {16'h0, phase}, 32'h0);
      check_eq("rst_valid", {31'h0, px_valid}, 32'h0);
      check_eq("rst_markers", {29'h0, sof, eol, eof}, 32'h0);
      check_eq("rst_busy", {31'h0, busy}, 32'h0);
      check_eq("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
      @(negedge clk);

      // 1: basic gradient frame, latency 2 cycles from start
      h_step = 16'h0100; v_step = 16'h1000; frame_step = 16'h0000;
      pulse_start();
      #1;
      check_eq("lat_load_valid", {31'h0, px_valid}, 32'h0);
      check_eq("lat_load_busy", {31'h0, busy}, 32'h1);
      @(negedge clk);
      #1;
      check_eq("lat_run_valid", {31'h0, px_valid}, 32'h1);
      check_eq("lat_run_phase", {16'h0, phase}, 32'h0);
      collect(8, 1'b0, -1);
      check_grad_frame("t1");
      #1;
      check_eq("t1_frame_cnt", {16'h0, frame_cnt}, 32'h1);
      check_eq("t1_valid_drop", {31'h0, px_valid}, 32'h0);

      // 2: base advances by frame_step across two frames
      do_reset();
      frame_step = 16'h0010;
      pulse_start();
      collect(16, 1'b0, -1);
      check_eq("t2_f2_first", {16'h0, got_ph[8]}, 32'h0010);
      check_eq("t2_f2_last", {16'h0, got_ph[15]}, 32'h1310);
      #1;
      check_eq("t2_frame_cnt", {16'h0, frame_cnt}, 32'h2);

      // 3: backpressure; holds are checked inside collect
      do_reset();
      frame_step = 16'h0000;
      pulse_start();
      collect(8, 1'b1, -1);
      check_grad_frame("t3");

      // 4: phase wraps modulo 2^16
      do_reset();
      h_step = 16'hC000; v_step = 16'h0000;
      pulse_start();
      collect(4, 1'b0, -1);
      for (int i = 0; i < 4; i++)
         check_eq("t4_wrap", {16'h0, got_ph[i]}, {16'h0, exp_wrap[i]});

      // 5: stop mid-frame completes the frame then idles; restart works
      do_reset();
      h_step = 16'h0100; v_step = 16'h1000; frame_step = 16'h0020;
      pulse_start();
      collect(8, 1'b0, 2);
      check_grad_frame("t5");
      #1;
      check_eq("t5_busy", {31'h0, busy}, 32'h0);
      check_eq("t5_valid", {31'h0, px_valid}, 32'h0);
      check_eq("t5_frame_cnt", {16'h0, frame_cnt}, 32'h1);
      repeat (3) @(negedge clk);
      check_eq("t5_still_idle", {31'h0, busy}, 32'h0);
      pulse_start();
      collect(1, 1'b0, -1);
      check_eq("t5_restart_phase", {16'h0, got_ph[0]}, 32'h0020);

      // 6: asynchronous reset mid-run clears everything including base
      do_reset();
      frame_step = 16'h0040;
      pulse_start();
      collect(10, 1'b0, -1);
      rst_n = 1'b0;
      #1;
      check_eq("t6_phase", {16'h0, phase}, 32'h0);
      check_eq("t6_valid", {31'h0, px_valid}, 32'h0);
      check_eq("t6_markers", {29'h0, sof, eol, eof}, 32'h0);
      check_eq("t6_busy", {31'h0, busy}, 32'h0);
      check_eq("t6_frame_cnt", {16'h0, frame_cnt}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      collect(1, 1'b0, -1);
      check_eq("t6_first_phase", {16'h0, got_ph[0]}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
